bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Sequential round-robin arbiter for the shared system bus, sitting between the per-master bus_req/bus_ack lines (icache = bit 0, dcache = bit 1, bits 2-7 reserved) and the wired-OR bus.
- Grants ownership as a registered one-hot bus_ack and holds it until the owner drops its request.
- Guarantees at least one dead cycle between owners, so the OR-combined addr/wdata/rd/wr never carry two masters' values at once.

Parameters:
- NREQ, 8: number of requesters.
- OWNER_W, 3: width of the owner index; must be at least ceil(log2(NREQ)).
- MAX_HOLD, 64: hold-cycle limit used only when BUS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- Nrst  in  1  asynchronous active-low reset.
- bus_req  in  NREQ  per-master request, level-held for the whole tenure.
- bus_rd  in  1  OR-combined bus read strobe; a transaction is in flight while high.
- bus_wr  in  1  OR-combined bus write strobe; a transaction is in flight while high.
- bus_ack  out  NREQ  registered one-hot grant; all-zero when the bus is unowned.
- bus_owner  out  OWNER_W  index of the current owner; holds the last owner while idle.
- bus_busy  out  1  high whenever any bit of bus_ack is high.

Behaviour:
- Reset (Nrst low, asynchronous):
  - bus_ack = 0, bus_busy = 0, bus_owner = 0.
  - Internal last_owner = NREQ-1, so requester 0 has first priority after reset.
  - State = IDLE, hold counter = 0.
  - Reset asserted mid-tenure drops the grant immediately, with no handshake.
- States: IDLE, OWNED, TURN.
- IDLE:
  - If bus_req is nonzero, search indices last_owner+1, last_owner+2, ... modulo NREQ and pick the first requester found.
  - At the next edge: bus_ack[w] = 1, bus_owner = w, last_owner = w, state -> OWNED.
  - Latency from request to ack is exactly 1 cycle for a request sampled in IDLE.
  - If bus_req is zero, stay in IDLE.
- OWNED:
  - While bus_req[bus_owner] = 1, hold bus_ack unchanged, whatever other requests do.
  - When bus_req[bus_owner] = 0 is sampled: at the next edge bus_ack = 0, state -> TURN.
- TURN:
  - One mandatory cycle with bus_ack = 0; then state -> IDLE unconditionally.
  - Requests are not evaluated in TURN.
  - Minimum gap between one owner's ack falling and the next owner's ack rising is 2 cycles. Example: ack drops at edge N, TURN is the cycle after N, IDLE samples at N+1, new ack rises at N+2.
- Fairness: the owner that just released has the lowest priority in the next arbitration. With all NREQ requesting continuously, each master is granted once per NREQ tenures.
- Re-grant: a master whose request drops and is re-raised during TURN can win again only if no other master is requesting.
- Request bits for indices at or above NREQ are not present; a requester that is not the owner and raises then drops its request while another master owns the bus is simply never granted.
- bus_rd and bus_wr are not used without the optional feature.
- Invariant: bus_ack is always zero or one-hot; a bench assertion checks this every cycle.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN, when defined:
  - A hold counter resets to 0 on each grant and increments each cycle in OWNED, saturating at MAX_HOLD.
  - Forced release happens when all three hold: count = MAX_HOLD, some other bus_req bit is high, and bus_rd = bus_wr = 0 (bus idle).
  - On forced release: at the next edge bus_ack = 0 and state -> TURN, exactly as for a voluntary release.
  - Preemption never happens while bus_rd or bus_wr is high; the arbiter waits for the bus to go idle.
- When not defined: no counter; an owner keeps the bus indefinitely.

Test Plan:
- Reset then bus_req = 8'b00000011 held -> bus_ack = 8'b00000001 one cycle after Nrst deasserts; bus_owner = 0; bus_busy = 1.
- From that state, drop bus_req[0] -> bus_ack = 0 next cycle, 1-cycle TURN, then bus_ack = 8'b00000010 with bus_owner = 1, two cycles after the ack fell.
- bus_req = 8'hFF, each owner drops its request one cycle after its grant and re-raises it during TURN -> grant order 0,1,2,...,7,0 with no repeats and no two bits set in bus_ack.
- Assert Nrst low while bus_ack = 8'b00000010 -> bus_ack = 0, bus_busy = 0, bus_owner = 0 asynchronously; after release with bus_req = 8'b00000010 -> master 1 granted first.
- BUS_ARB_TIMEOUT_EN with MAX_HOLD = 4: master 0 holds its request, master 1 requests, bus_rd = 1 for 10 cycles -> no preemption; bus_rd falls -> ack 0 drops next cycle, ack 1 rises 2 cycles later.
- Without BUS_ARB_TIMEOUT_EN, same stimulus held for 200 cycles -> bus_ack stays 8'b00000001 throughout.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus request/grant bundle between the bus masters and the round-robin arbiter.
// Ports: bus_req/bus_rd/bus_wr driven by the masters; bus_ack/bus_owner/bus_busy driven by the arbiter.
// Modports: master = requester side, slave = arbiter side.
interface bus_arbiter_rr_if #(
  parameter int NREQ    = 8,
  parameter int OWNER_W = 3
);
  logic [NREQ-1:0]    bus_req;
  logic               bus_rd;
  logic               bus_wr;
  logic [NREQ-1:0]    bus_ack;
  logic [OWNER_W-1:0] bus_owner;
  logic               bus_busy;

  modport master (
    output bus_req, bus_rd, bus_wr,
    input  bus_ack, bus_owner, bus_busy
  );

  modport slave (
    input  bus_req, bus_rd, bus_wr,
    output bus_ack, bus_owner, bus_busy
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Purpose: round-robin owner arbiter for the wired-OR system bus, one-hot registered grant.
// Latency: request sampled in IDLE -> ack 1 cycle later; ack fall -> next ack rise >= 2 cycles.
// Backpressure: owner keeps the bus while its request is held; others wait (optionally preempted
//   after MAX_HOLD cycles when BUS_ARB_TIMEOUT_EN is defined and the bus is idle).
// Ports: clk, Nrst (async active-low), bus (slave modport: bus_req, bus_rd, bus_wr in;
//   bus_ack, bus_owner, bus_busy out).
module bus_arbiter_rr #(
  parameter int NREQ     = 8,
  parameter int OWNER_W  = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              Nrst,
  bus_arbiter_rr_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWNED = 2'b01;
  localparam logic [1:0] ST_TURN  = 2'b10;

  logic [1:0]         state;
  logic [NREQ-1:0]    ack_q;
  logic [OWNER_W-1:0] owner_q;
  logic [OWNER_W-1:0] last_owner;
  logic [OWNER_W-1:0] winner;
  logic               force_rel;

  // Round-robin search: rotate the request vector so index last_owner+1 lands at
  // bit 0, take the lowest set bit, then rotate the index back.
  logic [NREQ-1:0] rot;
  int              shamt;
  int              pick;
  logic            found;

  always_comb begin
    shamt  = int'(last_owner) + 1;
    rot    = NREQ'({bus.bus_req, bus.bus_req} >> shamt);
    found  = 1'b0;
    pick   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pick  = i;
      end
    end
    pick = pick + shamt;
    if (pick >= NREQ) begin
      pick = pick - NREQ;
    end
    winner = OWNER_W'(pick);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              other_req;

  assign other_req = |(bus.bus_req & ~ack_q);
  // Preemption only between transactions, so an in-flight rd/wr is never cut.
  assign force_rel = (state == ST_OWNED) && (hold_cnt == HOLD_W'(MAX_HOLD)) &&
                     other_req && !bus.bus_rd && !bus.bus_wr;

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE && (|bus.bus_req)) begin
      hold_cnt <= '0;
    end else if (state == ST_OWNED && hold_cnt != HOLD_W'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  // Without the timeout the owner keeps the bus indefinitely; strobes are not needed.
  localparam int unused_max_hold = MAX_HOLD;
  logic unused_strobes;
  assign unused_strobes = bus.bus_rd ^ bus.bus_wr;
  assign force_rel      = 1'b0;
`endif

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state      <= ST_IDLE;
      ack_q      <= '0;
      owner_q    <= '0;
      last_owner <= OWNER_W'(NREQ - 1);  // requester 0 wins first after reset
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.bus_req) begin
            ack_q      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            owner_q    <= winner;
            last_owner <= winner;
            state      <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!bus.bus_req[owner_q] || force_rel) begin
            ack_q <= '0;
            state <= ST_TURN;
          end
        end
        ST_TURN: begin
          // Dead cycle: the bus OR-tree drains before anyone else is granted.
          state <= ST_IDLE;
        end
        default: begin
          ack_q <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_ack   = ack_q;
  assign bus.bus_owner = owner_q;
  assign bus.bus_busy  = |ack_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic clk;
  logic Nrst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [7:0] ack;
    logic [2:0] owner;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  bus_arbiter_rr_if #(.NREQ(8), .OWNER_W(3)) bus ();

  bus_arbiter_rr #(.NREQ(8), .OWNER_W(3), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .Nrst (Nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [7:0] a, input logic [2:0] o, input int at);
    exp_t e;
    e.ack   = a;
    e.owner = o;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Monitor: every change of bus_ack is an output event matched against the scoreboard.
  logic [7:0] prev_ack;
  initial prev_ack = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    total++;
    if (((bus.bus_ack & (bus.bus_ack - 8'd1)) != 8'h00) || (bus.bus_busy !== (|bus.bus_ack))) begin
      bad++;
      $display("FAIL onehot_busy: ack=%b busy=%b cyc=%0d", bus.bus_ack, bus.bus_busy, cyc);
    end
    if (bus.bus_ack != prev_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack=%b owner=%0d cyc=%0d want no change",
                 bus.bus_ack, bus.bus_owner, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.bus_ack !== e.ack || bus.bus_owner !== e.owner || cyc != e.at) begin
          bad++;
          $display("FAIL grant_event: got ack=%b owner=%0d cyc=%0d want ack=%b owner=%0d cyc=%0d",
                   bus.bus_ack, bus.bus_owner, cyc, e.ack, e.owner, e.at);
        end
      end
    end
    prev_ack = bus.bus_ack;
  end

  initial begin
    int r;
    int c;
    total       = 0;
    bad         = 0;
    Nrst        = 1'b1;
    bus.bus_req = 8'h00;
    bus.bus_rd  = 1'b0;
    bus.bus_wr  = 1'b0;
    #1 Nrst = 1'b0;
    tick(2);

    // Reset state
    chk("reset_ack", bus.bus_ack, 8'h00);
    chk("reset_busy", {7'd0, bus.bus_busy}, 8'h00);
    chk("reset_owner", {5'd0, bus.bus_owner}, 8'h00);

    // Masters 0 and 1 request; 0 has first priority after reset
    bus.bus_req = 8'b0000_0011;
    Nrst        = 1'b1;
    r           = cyc;
    push_ev(8'b0000_0001, 3'd0, r + 1);
    tick(1);
    chk("first_grant_busy", {7'd0, bus.bus_busy}, 8'h01);
    tick(2);

    // Owner 0 releases: ack falls next edge, TURN, then master 1 two cycles later
    bus.bus_req = 8'b0000_0010;
    c           = cyc;
    push_ev(8'h00, 3'd0, c + 1);
    push_ev(8'b0000_0010, 3'd1, c + 3);
    tick(3);
    chk("handover_owner", {5'd0, bus.bus_owner}, 8'h01);
    tick(2);

    // Reset mid-tenure drops the grant asynchronously
    Nrst = 1'b0;
    push_ev(8'h00, 3'd0, cyc);
    #1;
    chk("async_rst_ack", bus.bus_ack, 8'h00);
    chk("async_rst_busy", {7'd0, bus.bus_busy}, 8'h00);
    chk("async_rst_owner", {5'd0, bus.bus_owner}, 8'h00);
    tick(2);
    Nrst = 1'b1;
    r    = cyc;
    push_ev(8'b0000_0010, 3'd1, r + 1);
    tick(2);
    bus.bus_req = 8'h00;
    push_ev(8'h00, 3'd1, cyc + 1);
    tick(4);

    // All masters requesting: strict rotation 0..7 then 0 again
    Nrst = 1'b0;
    tick(1);
    bus.bus_req = 8'hFF;
    Nrst        = 1'b1;
    r           = cyc;
    for (int k = 0; k <= 8; k++) begin
      push_ev(8'h01 << (k % 8), 3'(k % 8), r + 1 + 4 * k);
      if (k < 8) push_ev(8'h00, 3'(k % 8), r + 3 + 4 * k);
    end
    tick(1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      bus.bus_req[k] = 1'b0;
      tick(1);
      bus.bus_req[k] = 1'b1;
      tick(2);
    end
    bus.bus_req = 8'h00;
    push_ev(8'h00, 3'd0, cyc + 1);
    tick(4);

    // Long hold by master 0 while master 1 waits and a read is in flight
    Nrst = 1'b0;
    tick(1);
    bus.bus_req = 8'b0000_0001;
    Nrst        = 1'b1;
    r           = cyc;
    push_ev(8'b0000_0001, 3'd0, r + 1);
    tick(1);
    bus.bus_req = 8'b0000_0011;
    bus.bus_rd  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
    tick(10);
    bus.bus_rd = 1'b0;
    c          = cyc;
    push_ev(8'h00, 3'd0, c + 1);
    push_ev(8'b0000_0010, 3'd1, c + 3);
    tick(3);
`else
    tick(10);
    bus.bus_rd = 1'b0;
    tick(190);
    chk("no_timeout_hold", bus.bus_ack, 8'b0000_0001);
    bus.bus_req = 8'b0000_0010;
    c           = cyc;
    push_ev(8'h00, 3'd0, c + 1);
    push_ev(8'b0000_0010, 3'd1, c + 3);
    tick(3);
`endif
    bus.bus_req = 8'h00;
    push_ev(8'h00, 3'd1, cyc + 1);
    tick(4);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d outstanding want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
